// File: rtl/mult_share_scheduler.sv
// mult_share_scheduler: lets NREQ requesters take turns on one multi-cycle
// multiplier. Round-robin grant, operand capture, one-cycle start pulse,
// completion on a rising edge of the operator's ready, and a watchdog
// that resets a hung operator and reports the lost operation as an error.
module mult_share_scheduler #(
    parameter int BW   = 16,
    parameter int NREQ = 4,
    parameter int TMO  = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*BW-1:0] A_IN,
    input  logic [NREQ*BW-1:0] B_IN,
    output logic [NREQ-1:0]   GNT,
    output logic [NREQ-1:0]   DONE,
    output logic              ERR,
    output logic [BW-1:0]     RES_OUT,
    output logic              BUSY,
    output logic              OP_ST,
    output logic              OP_RST,
    input  logic              OP_RD,
    input  logic [BW-1:0]     OP_RES,
    output logic [BW-1:0]     OP_IN0,
    output logic [BW-1:0]     OP_IN1
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TMO);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIN,
        RECOVER
    } state_t;

    state_t          state;
    state_t          nextState;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grantIdx;
    logic [PW-1:0]   winIdx;
    logic            anyReq;
    logic [TW-1:0]   timer;
    logic            rdPrev;
    logic            rdRise;
    logic            timeUp;
    logic [NREQ-1:0] gnt;
    logic [BW-1:0]   resOut;
    logic [BW-1:0]   opIn0;
    logic [BW-1:0]   opIn1;

    // A ready that is already high when the operation is issued must not count,
    // so completion is only ever a 0->1 transition seen while waiting.
    assign rdRise = OP_RD & ~rdPrev;
    assign timeUp = (timer == TW'(TMO - 1));

    // Round-robin search starting just after the last served requester;
    // scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        anyReq = 1'b0;
        winIdx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (REQ[PW'((int'(ptr) + k) % NREQ)]) begin
                anyReq = 1'b1;
                winIdx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decision; a ready edge on the final wait cycle beats the timeout.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT: begin
                if (rdRise) begin
                    nextState = FIN;
                end else if (timeUp) begin
                    nextState = RECOVER;
                end
            end
            FIN:     nextState = IDLE;
            RECOVER: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Grant, operand capture, wait timer, ready history, result and pointer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt      <= '0;
            grantIdx <= '0;
            ptr      <= PW'(NREQ - 1);
            opIn0    <= '0;
            opIn1    <= '0;
            timer    <= '0;
            rdPrev   <= 1'b1;
            resOut   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        gnt      <= NREQ'(1) << winIdx;
                        grantIdx <= winIdx;
                        opIn0    <= A_IN[winIdx*BW +: BW];
                        opIn1    <= B_IN[winIdx*BW +: BW];
                    end
                end
                ISSUE: begin
                    timer  <= '0;
                    rdPrev <= OP_RD;
                end
                WAIT: begin
                    rdPrev <= OP_RD;
                    if (rdRise) begin
                        resOut <= OP_RES;
                    end else if (timeUp) begin
                        resOut <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                FIN, RECOVER: begin
                    gnt <= '0;
                    ptr <= grantIdx;
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

    // Per-state outputs; the operator is held in reset for as long as we are.
    always_comb begin
        OP_ST  = (state == ISSUE);
        BUSY   = (state != IDLE);
        DONE   = ((state == FIN) || (state == RECOVER)) ? gnt : '0;
        ERR    = (state == RECOVER);
        OP_RST = !RST || (state == RECOVER);
    end

    assign GNT     = gnt;
    assign RES_OUT = resOut;
    assign OP_IN0  = opIn0;
    assign OP_IN1  = opIn1;

endmodule

// File: tb/tb_mult_share_scheduler.sv
// tb_mult_share_scheduler: drives requesters and a behavioural multiplier,
// predicting grants, results, completion timing and error reporting from a
// transaction-level round-robin model.
module tb_mult_share_scheduler;

    localparam int BW   = 16;
    localparam int NREQ = 4;
    localparam int TMO  = 64;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    REQ;
    logic [NREQ*BW-1:0] A_IN;
    logic [NREQ*BW-1:0] B_IN;
    logic [NREQ-1:0]    GNT;
    logic [NREQ-1:0]    DONE;
    logic               ERR;
    logic [BW-1:0]      RES_OUT;
    logic               BUSY;
    logic               OP_ST;
    logic               OP_RST;
    logic               OP_RD;
    logic [BW-1:0]      OP_RES;
    logic [BW-1:0]      OP_IN0;
    logic [BW-1:0]      OP_IN1;

    logic [BW-1:0] aVal [NREQ];
    logic [BW-1:0] bVal [NREQ];
    int total = 0;
    int bad = 0;
    int lastServed = NREQ - 1;

    mult_share_scheduler #(.BW(BW), .NREQ(NREQ), .TMO(TMO)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
        .GNT(GNT), .DONE(DONE), .ERR(ERR), .RES_OUT(RES_OUT), .BUSY(BUSY),
        .OP_ST(OP_ST), .OP_RST(OP_RST), .OP_RD(OP_RD), .OP_RES(OP_RES),
        .OP_IN0(OP_IN0), .OP_IN1(OP_IN1)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Pack each requester's operands into the shared buses.
    always_comb begin
        A_IN = '0;
        B_IN = '0;
        for (int i = 0; i < NREQ; i++) begin
            A_IN[i*BW +: BW] = aVal[i];
            B_IN[i*BW +: BW] = bVal[i];
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [BW-1:0] a, input logic [BW-1:0] b);
        aVal[idx] = a;
        bVal[idx] = b;
        REQ[idx]  = 1'b1;
    endtask

    // One whole operation: predict winner, play the operator (ready rises d
    // cycles after the start cycle, or never if d<0), then check completion.
    task automatic runOp(input int dIn, input int lowAt, input int expStWait,
                         input bit dropReq, output int gotIdx);
        int expIdx, d, c, stWait, stCount, expCycle;
        bit stale, got, tmo;
        logic [BW-1:0] ea, eb, eres, opA, opB;
        logic [2*BW-1:0] prod;
        expIdx = -1;
        gotIdx = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (lastServed + k) % NREQ;
            if (expIdx < 0 && REQ[idx]) expIdx = idx;
        end
        if (expIdx < 0) begin
            checkOutput("no_request", 0, 1);
            return;
        end
        ea = aVal[expIdx];
        eb = bVal[expIdx];
        prod = ea * eb;
        eres = prod[BW-1:0];
        stWait = 0;
        do begin
            @(negedge CLK);
            stWait++;
        end while (!OP_ST && stWait < 8);
        if (!OP_ST) begin
            checkOutput("st_missing", 32'(OP_ST), 1);
            return;
        end
        if (expStWait >= 0) checkOutput("st_latency", stWait, expStWait);
        for (int i = 0; i < NREQ; i++) if (GNT[i]) gotIdx = i;
        checkOutput("gnt", 32'(GNT), 1 << expIdx);
        checkOutput("op_in0", 32'(OP_IN0), 32'(ea));
        checkOutput("op_in1", 32'(OP_IN1), 32'(eb));
        checkOutput("busy", 32'(BUSY), 1);
        opA = OP_IN0;
        opB = OP_IN1;
        stale = OP_RD;
        aVal[expIdx] = BW'($urandom);
        bVal[expIdx] = BW'($urandom);
        d = dIn;
        if (stale && d >= 0 && d <= lowAt) d = lowAt + 1;
        tmo = (d < 0) || (d > TMO);
        expCycle = tmo ? TMO + 1 : d + 1;
        c = 0;
        stCount = 1;
        got = 1'b0;
        while (!got && c < TMO + 8) begin
            @(negedge CLK);
            c++;
            if (OP_ST) stCount++;
            if (DONE != '0) begin
                got = 1'b1;
                checkOutput("done_cycle", c, expCycle);
                checkOutput("done", 32'(DONE), 1 << expIdx);
                checkOutput("gnt_hold", 32'(GNT), 1 << expIdx);
                checkOutput("err", 32'(ERR), 32'(tmo));
                checkOutput("res", 32'(RES_OUT), tmo ? 0 : 32'(eres));
                checkOutput("op_rst", 32'(OP_RST), 32'(tmo));
                checkOutput("st_once", stCount, 1);
                if (dropReq) REQ[expIdx] = 1'b0;
            end else begin
                if (c == expCycle - 1) begin
                    checkOutput("op_rst_pre", 32'(OP_RST), 0);
                    checkOutput("err_pre", 32'(ERR), 0);
                end
                if (stale && c == lowAt) OP_RD = 1'b0;
                if (c == d) begin
                    prod = opA * opB;
                    OP_RES = prod[BW-1:0];
                    OP_RD = 1'b1;
                end
            end
        end
        if (!got) begin
            checkOutput("done_missing", 0, 1);
            return;
        end
        @(negedge CLK);
        checkOutput("done_pulse", 32'(DONE), 0);
        checkOutput("op_rst_post", 32'(OP_RST), 0);
        checkOutput("err_post", 32'(ERR), 0);
        checkOutput("gnt_clear", 32'(GNT), 0);
        checkOutput("res_hold", 32'(RES_OUT), tmo ? 0 : 32'(eres));
        lastServed = expIdx;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int gotIdx, d, cnt;
        RST = 1'b0;
        REQ = '0;
        OP_RD = 1'b0;
        OP_RES = '0;
        for (int i = 0; i < NREQ; i++) begin
            aVal[i] = '0;
            bVal[i] = '0;
        end
        #2;
        checkOutput("rst_gnt", 32'(GNT), 0);
        checkOutput("rst_done", 32'(DONE), 0);
        checkOutput("rst_err", 32'(ERR), 0);
        checkOutput("rst_res", 32'(RES_OUT), 0);
        checkOutput("rst_st", 32'(OP_ST), 0);
        checkOutput("rst_in0", 32'(OP_IN0), 0);
        checkOutput("rst_in1", 32'(OP_IN1), 0);
        checkOutput("rst_busy", 32'(BUSY), 0);
        checkOutput("rst_oprst", 32'(OP_RST), 1);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("rel_oprst", 32'(OP_RST), 0);

        $display("[TB] single request");
        applyStimulus(0, 16'd4, 16'd5);
        runOp(12, 1, 1, 1'b1, gotIdx);
        checkOutput("idle_busy", 32'(BUSY), 0);

        $display("[TB] simultaneous requests");
        applyStimulus(1, 16'd3, 16'd7);
        applyStimulus(3, 16'd6, 16'd6);
        runOp(9, 1, 1, 1'b1, gotIdx);
        checkOutput("sim_first", gotIdx, 1);
        runOp(4, 1, 1, 1'b1, gotIdx);
        checkOutput("sim_second", gotIdx, 3);

        $display("[TB] fairness");
        for (int i = 0; i < NREQ; i++) applyStimulus(i, BW'($urandom), BW'($urandom));
        for (int n = 0; n < 8; n++) begin
            runOp(int'($urandom_range(1, 20)), 1, 1, 1'b0, gotIdx);
            checkOutput("rr_order", gotIdx, n % NREQ);
        end
        REQ = '0;
        @(negedge CLK);

        $display("[TB] stale ready");
        OP_RD = 1'b1;
        applyStimulus(0, 16'd11, 16'd13);
        runOp(8, 3, 1, 1'b1, gotIdx);

        $display("[TB] watchdog");
        OP_RD = 1'b0;
        applyStimulus(2, 16'd100, 16'd200);
        runOp(-1, 1, 1, 1'b1, gotIdx);
        applyStimulus(3, 16'd9, 16'd8);
        runOp(7, 1, 1, 1'b1, gotIdx);
        checkOutput("after_tmo", gotIdx, 3);
        applyStimulus(1, 16'hffff, 16'hffff);
        runOp(TMO, 1, 1, 1'b1, gotIdx);
        applyStimulus(2, 16'd3, 16'd3);
        runOp(TMO + 1, 1, 1, 1'b1, gotIdx);

        $display("[TB] random traffic");
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!REQ[i] && $urandom_range(0, 1) == 1) applyStimulus(i, BW'($urandom), BW'($urandom));
            end
            if (REQ == '0) applyStimulus(int'($urandom_range(0, NREQ - 1)), BW'($urandom), BW'($urandom));
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 30));
            runOp(d, int'($urandom_range(1, 3)), 1, 1'b1, gotIdx);
        end
        for (int n = 0; n < NREQ && REQ != '0; n++) runOp(5, 1, 1, 1'b1, gotIdx);

        $display("[TB] reset mid-operation");
        OP_RD = 1'b0;
        applyStimulus(2, 16'd9, 16'd9);
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("mid_gnt", 32'(GNT), 0);
        checkOutput("mid_done", 32'(DONE), 0);
        checkOutput("mid_err", 32'(ERR), 0);
        checkOutput("mid_busy", 32'(BUSY), 0);
        checkOutput("mid_st", 32'(OP_ST), 0);
        checkOutput("mid_in0", 32'(OP_IN0), 0);
        checkOutput("mid_in1", 32'(OP_IN1), 0);
        checkOutput("mid_res", 32'(RES_OUT), 0);
        checkOutput("mid_oprst", 32'(OP_RST), 1);
        REQ = '0;
        OP_RD = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        lastServed = NREQ - 1;
        cnt = 0;
        repeat (8) begin
            @(negedge CLK);
            if (DONE != '0 || BUSY) cnt++;
        end
        checkOutput("no_done_after_rst", cnt, 0);
        applyStimulus(0, 16'd21, 16'd2);
        applyStimulus(3, 16'd5, 16'd5);
        runOp(5, 1, 1, 1'b1, gotIdx);
        checkOutput("rst_ptr", gotIdx, 0);
        runOp(6, 1, 1, 1'b1, gotIdx);
        checkOutput("rst_next", gotIdx, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_share_scheduler.md
Name: mult_share_scheduler

Overview:
- Shares one multi-cycle multiplication operator among NREQ requesters; the operator uses the ST/RD start/ready handshake with RES, IN0 and IN1.
- Round-robin arbitration, operand capture, ST pulse generation, and RD detection with per-requester completion.
- Watchdog timeout resets a hung operator.
- Sits between requester datapaths and a single composition multiplier instance, bw=16, icnt=2.

Parameters:
- BW, 16, operand/result width.
- NREQ, 4, number of requesters (2..8).
- TMO, 64, max cycles in WAIT before recovery (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  per-requester request level; held until that requester's DONE bit.
- A_IN  in  NREQ*BW  operand 0, requester i at bits [i*BW +: BW].
- B_IN  in  NREQ*BW  operand 1, same packing.
- GNT  out  NREQ  one-hot grant; held for the whole operation.
- DONE  out  NREQ  one-cycle completion pulse to the granted requester.
- ERR  out  1  high together with DONE when the operation timed out.
- RES_OUT  out  BW  result; valid while DONE is high, then held.
- BUSY  out  1  high in any state except IDLE.
- OP_ST  out  1  operator start.
- OP_RST  out  1  operator reset, active-high.
- OP_RD  in  1  operator ready.
- OP_RES  in  BW  operator result.
- OP_IN0  out  BW  latched operand 0.
- OP_IN1  out  BW  latched operand 1.

Behaviour:
- Reset (RST=0, asynchronous):
  - State=IDLE; GNT, DONE, ERR, RES_OUT, OP_ST, OP_IN0, OP_IN1 = 0.
  - Round-robin pointer = NREQ-1, so requester 0 has highest priority first.
  - OP_RST = 1 combinationally while RST=0.
  - The RD-history register is loaded with 1.
  - Reset mid-operation abandons the operation; no DONE is produced.
- States: IDLE, ISSUE, WAIT, FIN, RECOVER.
- IDLE:
  - If any REQ bit is set, pick the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - Register GNT one-hot for the winner.
  - Latch that requester's A/B slices into OP_IN0/OP_IN1.
  - Go to ISSUE. Operands are sampled only here; later changes to A_IN/B_IN are ignored.
- ISSUE:
  - OP_ST=1 for exactly this cycle.
  - Timer cleared, RD-history register loaded with current OP_RD.
  - Go to WAIT.
- WAIT:
  - Completion is a rising edge of OP_RD (current 1, previous 0).
  - A level high that was already present at ISSUE is ignored, which covers a stale RD from the previous operation.
  - On a rising edge: RES_OUT <= OP_RES; go to FIN.
  - Otherwise, timer increments; when timer == TMO-1 with no edge, go to RECOVER. A rising edge on that same cycle wins over the timeout.
- FIN:
  - DONE[g]=1 and ERR=0 for one cycle.
  - GNT cleared and ptr <= g at the end of the cycle; go to IDLE.
- RECOVER:
  - OP_RST=1, DONE[g]=1, ERR=1 and RES_OUT <= 0, all for one cycle.
  - GNT cleared, ptr <= g; go to IDLE.
- Latency:
  - REQ sampled at edge k → GNT high and OP_ST high in cycle k+1.
  - WAIT starts at k+2.
  - DONE appears 1 cycle after the RD rising edge is sampled.
  - Minimum turnaround between back-to-back grants: 1 IDLE cycle.
- Requester rules:
  - Requesters drop REQ the cycle after seeing DONE.
  - REQ deasserted mid-operation does not abort; DONE still pulses.
  - A REQ present at DONE time is re-arbitrated normally in IDLE; round-robin prevents starvation.
- Result width: RES_OUT carries the operator's BW-bit result unmodified. Overflow truncation is the operator's responsibility and is not flagged.
- GNT is always zero or one-hot. DONE is always zero or equal to the GNT that was just cleared.

Test Plan:
- Single request: REQ=0001, A0=4, B0=5; model operator raises RD 12 cycles after ST → OP_ST one cycle at k+1, OP_IN0=4, OP_IN1=5, DONE=0001 with RES_OUT=20, ERR=0, BUSY low afterwards.
- Simultaneous requests: REQ=1010 after reset (A1=3, B1=7; A3=6, B3=6) → requester 1 served first (RES_OUT=21), then requester 3 (RES_OUT=36); exactly one OP_ST per operation.
- Fairness: all four REQ held continuously for 8 operations → grant order 0,1,2,3,0,1,2,3; no requester is granted twice in a row while others wait.
- Stale RD: OP_RD stuck at 1 through ISSUE, falls 3 cycles later, rises 5 cycles after that → DONE only after the second rise; the initial high does not complete the operation.
- Timeout: operator never raises RD, TMO=64 → RECOVER entered 64 cycles into WAIT; OP_RST pulses one cycle; DONE[g]=1 with ERR=1 and RES_OUT=0; the next request proceeds normally.
- Reset mid-operation: RST low during WAIT → all outputs zero immediately (before the next clock); OP_RST high while RST low; no DONE after release; a new REQ=0001 goes to requester 0.
